fetch_decode_alu_pipe: RTL and testbench

//  Front-end of the AsyncARM core. Fetches a 32-bit ARM word from ROM at the PC held in the regbank.

---
 rtl/fda_pkg.sv | 62 ++++++
 rtl/alu_core.sv | 57 +++++
 rtl/fetch_decode_alu_pipe.sv | 142 ++++++++++++++
 tb/tb_fetch_decode_alu_pipe.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fda_pkg.sv
// Shared types for the fetch/decode/ALU front-end: sequencer states,
// data-processing opcodes, condition codes and CPSR flag positions.
package fda_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_FWAIT, S_COND, S_RD_RN, S_RN_WAIT,
    S_RD_RM, S_RM_WAIT, S_EXEC, S_OUT
  } state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3,
    OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7,
    OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB,
    OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF
  } dp_op_t;

  typedef enum logic [3:0] {
    C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
    C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
    C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
    C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
  } cond_t;

  localparam int unsigned FLAG_N = 31;
  localparam int unsigned FLAG_Z = 30;
  localparam int unsigned FLAG_C = 29;
  localparam int unsigned FLAG_V = 28;

  // True when the condition field passes against the given NZCV nibble.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond_t'(cond))
      C_EQ:    return z;
      C_NE:    return !z;
      C_CS:    return c;
      C_CC:    return !c;
      C_MI:    return n;
      C_PL:    return !n;
      C_VS:    return v;
      C_VC:    return !v;
      C_HI:    return c && !z;
      C_LS:    return !c || z;
      C_GE:    return n == v;
      C_LT:    return n != v;
      C_GT:    return !z && (n == v);
      C_LE:    return z || (n != v);
      C_AL:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // imm8 rotated right by twice the 4-bit rotate field.
  function automatic logic [31:0] rot_imm(input logic [11:0] field);
    logic [63:0] dbl;
    logic [5:0]  amt;
    dbl = {24'd0, field[7:0], 24'd0, field[7:0]};
    amt = {1'b0, field[11:8], 1'b0};
    return 32'(dbl >> amt);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ARM data-processing ALU: result, NZCV and write-enable.
module alu_core
  import fda_pkg::*;
(
  input  dp_op_t      op,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic        sh_carry,
  input  logic        c_in,
  input  logic        v_in,
  output logic [31:0] result,
  output logic [3:0]  nzcv,
  output logic        we
);

  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        arith;
  logic [32:0] sum;

  // Subtractions are folded into a single 33-bit adder via inverted operands.
  always_comb begin
    a      = op1;
    b      = op2;
    cin    = 1'b0;
    arith  = 1'b0;
    result = '0;
    case (op)
      OP_AND, OP_TST: result = op1 & op2;
      OP_EOR, OP_TEQ: result = op1 ^ op2;
      OP_ORR:         result = op1 | op2;
      OP_MOV:         result = op2;
      OP_BIC:         result = op1 & ~op2;
      OP_MVN:         result = ~op2;
      OP_SUB, OP_CMP: begin b = ~op2; cin = 1'b1; arith = 1'b1; end
      OP_RSB:         begin a = op2; b = ~op1; cin = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: arith = 1'b1;
      OP_ADC:         begin cin = c_in; arith = 1'b1; end
      OP_SBC:         begin b = ~op2; cin = c_in; arith = 1'b1; end
      OP_RSC:         begin a = op2; b = ~op1; cin = c_in; arith = 1'b1; end
      default:        result = '0;
    endcase
    sum = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    if (arith) result = sum[31:0];
  end

  // Flags: arithmetic ops own C and V, logical ops take shifter carry and keep V.
  always_comb begin
    nzcv[3] = result[31];
    nzcv[2] = (result == '0);
    nzcv[1] = arith ? sum[32] : sh_carry;
    nzcv[0] = arith ? ((a[31] == b[31]) && (sum[31] != a[31])) : v_in;
    we      = (op[3:2] != 2'b10);
  end

endmodule

// File: rtl/fetch_decode_alu_pipe.sv
// Non-pipelined fetch/decode/execute sequencer for ARM data-processing ops.
module fetch_decode_alu_pipe
  import fda_pkg::*;
#(
  parameter logic [31:0] PC_STEP = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] romAddr,
  output logic        romTrigger,
  input  logic        romReady,
  input  logic [31:0] romData,
  input  logic [31:0] pcIn,
  output logic [31:0] pcOut,
  output logic        pcWrite,
  input  logic [31:0] cpsrIn,
  output logic [3:0]  rbAddr,
  output logic        rbTrigger,
  input  logic        rbReady,
  input  logic [31:0] rbData,
  output logic [31:0] dataOut1,
  output logic [31:0] dataOut2,
  output logic [31:0] cpsrOut,
  output logic [31:0] srcDstOut,
  output logic        w,
  input  logic        triggerIn,
  output logic        readyOut
);

  state_t      state, nstate;
  logic [31:0] instr_q, op1_q, rm_q;
  logic        is_imm, supported, cond_ok, uses_rn, uses_rm;
  dp_op_t      opcode;
  logic [31:0] op2_sel, alu_res;
  logic        sh_carry, alu_we;
  logic [3:0]  alu_nzcv;
  logic        rom_trig_d, rb_trig_d, pc_write_d;
  logic [3:0]  rb_addr_d;

  // Instruction decode from the latched word.
  always_comb begin
    is_imm    = instr_q[25];
    opcode    = dp_op_t'(instr_q[24:21]);
    supported = (instr_q[27:26] == 2'b00) && (is_imm || (instr_q[11:4] == 8'd0));
    cond_ok   = cond_pass(instr_q[31:28], cpsrIn[FLAG_N:FLAG_V]);
    uses_rn   = (opcode != OP_MOV) && (opcode != OP_MVN);
    uses_rm   = !is_imm;
    op2_sel   = is_imm ? rot_imm(instr_q[11:0]) : rm_q;
    sh_carry  = (is_imm && (instr_q[11:8] != 4'd0)) ? op2_sel[31] : cpsrIn[FLAG_C];
  end

  alu_core u_alu (
    .op       (opcode),
    .op1      (op1_q),
    .op2      (op2_sel),
    .sh_carry (sh_carry),
    .c_in     (cpsrIn[FLAG_C]),
    .v_in     (cpsrIn[FLAG_V]),
    .result   (alu_res),
    .nzcv     (alu_nzcv),
    .we       (alu_we)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= nstate;
  end

  // Next-state logic.
  always_comb begin
    nstate = state;
    case (state)
      S_FETCH:   nstate = S_FWAIT;
      S_FWAIT:   if (romReady) nstate = S_COND;
      S_COND: begin
        if (!(cond_ok && supported)) nstate = S_FETCH;
        else if (uses_rn)            nstate = S_RD_RN;
        else if (uses_rm)            nstate = S_RD_RM;
        else                         nstate = S_EXEC;
      end
      S_RD_RN:   nstate = S_RN_WAIT;
      S_RN_WAIT: if (rbReady) nstate = uses_rm ? S_RD_RM : S_EXEC;
      S_RD_RM:   nstate = S_RM_WAIT;
      S_RM_WAIT: if (rbReady) nstate = S_EXEC;
      S_EXEC:    nstate = S_OUT;
      S_OUT:     if (triggerIn) nstate = S_FETCH;
      default:   nstate = S_FETCH;
    endcase
  end

  // Strobe decode; strobes are registered so they stay low during reset.
  always_comb begin
    rom_trig_d = (state == S_FETCH);
    rb_trig_d  = (state == S_RD_RN) || (state == S_RD_RM);
    rb_addr_d  = (state == S_RD_RM) ? instr_q[3:0] : instr_q[19:16];
    pc_write_d = (state == S_FWAIT) && romReady;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      romAddr    <= '0;
      romTrigger <= 1'b0;
      pcOut      <= '0;
      pcWrite    <= 1'b0;
      rbAddr     <= '0;
      rbTrigger  <= 1'b0;
      instr_q    <= '0;
      op1_q      <= '0;
      rm_q       <= '0;
      dataOut1   <= '0;
      dataOut2   <= '0;
      cpsrOut    <= '0;
      srcDstOut  <= '0;
      w          <= 1'b0;
      readyOut   <= 1'b0;
    end else begin
      romTrigger <= rom_trig_d;
      rbTrigger  <= rb_trig_d;
      pcWrite    <= pc_write_d;
      if (state == S_FETCH) romAddr <= pcIn;
      if (pc_write_d) begin
        instr_q <= romData;
        pcOut   <= romAddr + PC_STEP;
      end
      if (rb_trig_d) rbAddr <= rb_addr_d;
      if (state == S_RN_WAIT && rbReady) op1_q <= rbData;
      if (state == S_RM_WAIT && rbReady) rm_q  <= rbData;
      if (state == S_EXEC) begin
        dataOut1  <= alu_res;
        dataOut2  <= op2_sel;
        cpsrOut   <= instr_q[20] ? {alu_nzcv, cpsrIn[27:0]} : cpsrIn;
        srcDstOut <= {28'd0, instr_q[15:12]};
        w         <= alu_we;
        readyOut  <= 1'b1;
      end
      if (state == S_OUT && triggerIn) readyOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_decode_alu_pipe.sv
// Directed bench for fetch_decode_alu_pipe with ROM/regbank responders.
module tb_fetch_decode_alu_pipe;

  logic        clk, reset;
  logic [31:0] romAddr, romData, pcIn, pcOut, cpsrIn, rbData;
  logic        romTrigger, romReady, pcWrite, rbTrigger, rbReady;
  logic [3:0]  rbAddr;
  logic [31:0] dataOut1, dataOut2, cpsrOut, srcDstOut;
  logic        w, triggerIn, readyOut;

  int checks = 0;
  int failures = 0;

  logic [31:0] rom_word;
  logic [31:0] regs [16];
  logic [31:0] rom_log[$];
  logic [3:0]  rb_log[$];
  int          pw_count = 0;

  fetch_decode_alu_pipe #(.PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset),
    .romAddr(romAddr), .romTrigger(romTrigger), .romReady(romReady), .romData(romData),
    .pcIn(pcIn), .pcOut(pcOut), .pcWrite(pcWrite), .cpsrIn(cpsrIn),
    .rbAddr(rbAddr), .rbTrigger(rbTrigger), .rbReady(rbReady), .rbData(rbData),
    .dataOut1(dataOut1), .dataOut2(dataOut2), .cpsrOut(cpsrOut), .srcDstOut(srcDstOut),
    .w(w), .triggerIn(triggerIn), .readyOut(readyOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM, regbank and PC register models respond one half-cycle after a request.
  initial begin
    forever begin
      @(negedge clk);
      romReady = romTrigger;
      romData  = romTrigger ? rom_word : '0;
      rbReady  = rbTrigger;
      rbData   = rbTrigger ? regs[rbAddr] : '0;
      if (romTrigger) rom_log.push_back(romAddr);
      if (rbTrigger)  rb_log.push_back(rbAddr);
      if (pcWrite) begin
        pcIn = pcOut;
        pw_count++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic load(input logic [31:0] word, input logic [31:0] r0,
                      input logic [31:0] r1, input logic [31:0] cpsr);
    @(posedge clk);
    #1;
    rom_word = word;
    regs[0]  = r0;
    regs[1]  = r1;
    cpsrIn   = cpsr;
    rom_log.delete();
    rb_log.delete();
  endtask

  task automatic consume();
    if (readyOut) begin
      @(negedge clk);
      triggerIn = 1'b1;
      @(negedge clk);
      triggerIn = 1'b0;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!readyOut && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!readyOut) begin
      failures++;
      $display("FAIL %s ready_timeout got=0 exp=1", name);
    end
    checks++;
  endtask

  task automatic test_reset();
    logic [228:0] all_out;
    reset = 1'b0;
    pcIn = '0;
    cpsrIn = 32'hF00000D3;
    rom_word = 32'hE3A010FF;
    repeat (5) @(negedge clk);
    all_out = {romAddr, romTrigger, pcOut, pcWrite, rbAddr, rbTrigger, dataOut1,
               dataOut2, cpsrOut, srcDstOut, w, readyOut};
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", all_out);
    end
    checks++;
    cpsrIn = 32'h00000013;
    rb_log.delete();
    rom_log.delete();
    reset = 1'b1;
    for (int i = 0; i < 10 && !romTrigger; i++) @(negedge clk);
    if (romTrigger !== 1'b1 || romAddr !== 32'd0) begin
      failures++;
      $display("FAIL first_fetch got=%b/%h exp=1/00000000", romTrigger, romAddr);
    end
    checks++;
    for (int i = 0; i < 10 && !pcWrite; i++) @(negedge clk);
    if (pcWrite !== 1'b1 || pcOut !== 32'd4) begin
      failures++;
      $display("FAIL first_pcwrite got=%b/%h exp=1/00000004", pcWrite, pcOut);
    end
    checks++;
  endtask

  task automatic test_mov();
    wait_ready("mov");
    if (rb_log.size() != 0) begin
      failures++;
      $display("FAIL mov_no_rb got=%0d exp=0", rb_log.size());
    end
    checks++;
    if ({dataOut1, srcDstOut, w, readyOut} !== {32'hFF, 32'd1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL mov_out got=%h/%h/%b/%b exp=000000ff/00000001/1/1",
               dataOut1, srcDstOut, w, readyOut);
    end
    checks++;
    if (cpsrOut !== 32'h00000013) begin
      failures++;
      $display("FAIL mov_cpsr got=%h exp=00000013", cpsrOut);
    end
    checks++;
  endtask

  task automatic test_adds();
    load(32'hE0902001, 32'hFFFFFFFF, 32'd1, 32'h00000013);
    consume();
    if (readyOut !== 1'b0) begin
      failures++;
      $display("FAIL consume_drops_ready got=%b exp=0", readyOut);
    end
    checks++;
    wait_ready("adds");
    if (rb_log.size() != 2 || rb_log[0] !== 4'd0 || rb_log[1] !== 4'd1) begin
      failures++;
      $display("FAIL adds_rb_order got_n=%0d exp=2 (0 then 1)", rb_log.size());
    end
    checks++;
    if (dataOut1 !== 32'd0 || cpsrOut !== 32'h60000013) begin
      failures++;
      $display("FAIL adds_res got=%h/%h exp=00000000/60000013", dataOut1, cpsrOut);
    end
    checks++;
    if (romAddr !== 32'd4 || srcDstOut !== 32'd2) begin
      failures++;
      $display("FAIL adds_addr_rd got=%h/%h exp=00000004/00000002", romAddr, srcDstOut);
    end
    checks++;
  endtask

  task automatic test_cmp_rot();
    load(32'hE1500001, 32'd5, 32'd5, 32'h000000D3);
    consume();
    wait_ready("cmp");
    if (w !== 1'b0 || cpsrOut !== 32'h600000D3) begin
      failures++;
      $display("FAIL cmp got=%b/%h exp=0/600000d3", w, cpsrOut);
    end
    checks++;
    load(32'hE3A01101, 32'd0, 32'd0, 32'h000000D3);
    consume();
    wait_ready("mov_ror");
    if (dataOut1 !== 32'h40000000 || dataOut2 !== 32'h40000000 || cpsrOut !== 32'h000000D3) begin
      failures++;
      $display("FAIL mov_ror got=%h/%h/%h exp=40000000/40000000/000000d3",
               dataOut1, dataOut2, cpsrOut);
    end
    checks++;
  endtask

  task automatic test_cond_fail();
    logic saw_ready;
    int   pw0;
    load(32'h03A010FF, 32'd0, 32'd0, 32'h00000000);
    pw0 = pw_count;
    consume();
    saw_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (readyOut) saw_ready = 1'b1;
    end
    if (saw_ready) begin
      failures++;
      $display("FAIL condfail_ready got=1 exp=0");
    end
    checks++;
    if (rom_log.size() < 2 || rom_log[0] !== 32'd16 || rom_log[1] !== 32'd20) begin
      failures++;
      $display("FAIL condfail_addr got_n=%0d exp=16 then 20", rom_log.size());
    end
    checks++;
    if (pw_count - pw0 < 2) begin
      failures++;
      $display("FAIL condfail_pcwrite got=%0d exp>=2", pw_count - pw0);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    // word, r0, r1, cpsr, expected result, expected cpsrOut, w, Rd
    logic [31:0] tw [8] = '{32'hE0503001, 32'hE0904001, 32'hE0305001, 32'hE0B06001,
                            32'hE3E07000, 32'hE3B01102, 32'hE2708000, 32'hE1100001};
    logic [31:0] t0 [8] = '{32'h0, 32'h7FFFFFFF, 32'hF0F0F0F0, 32'h1,
                            32'h0, 32'h0, 32'h5, 32'hF0};
    logic [31:0] t1 [8] = '{32'h1, 32'h1, 32'hFFFFFFFF, 32'h2,
                            32'h0, 32'h0, 32'h0, 32'h0F};
    logic [31:0] tc [8] = '{32'h13, 32'h13, 32'h30000013, 32'h20000013,
                            32'hF0000013, 32'h13, 32'h13, 32'h10000013};
    logic [31:0] td [8] = '{32'hFFFFFFFF, 32'h80000000, 32'h0F0F0F0F, 32'h4,
                            32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFB, 32'h0};
    logic [31:0] tf [8] = '{32'h80000013, 32'h90000013, 32'h30000013, 32'h00000013,
                            32'hF0000013, 32'hA0000013, 32'h80000013, 32'h50000013};
    logic        tww [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  trd [8] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd1, 4'd8, 4'd0};
    for (int i = 0; i < 8; i++) begin
      load(tw[i], t0[i], t1[i], tc[i]);
      consume();
      wait_ready("b2b");
      if (dataOut1 !== td[i] || cpsrOut !== tf[i] || w !== tww[i] ||
          srcDstOut !== {28'd0, trd[i]}) begin
        failures++;
        $display("FAIL b2b_%0d got=%h/%h/%b/%h exp=%h/%h/%b/%h", i, dataOut1, cpsrOut,
                 w, srcDstOut, td[i], tf[i], tww[i], {28'd0, trd[i]});
      end
      checks++;
    end
  endtask

  task automatic test_hold_reset();
    logic [31:0] d1, d2, cf, sd;
    logic        ok, wv;
    logic [228:0] all_out;
    d1 = dataOut1; d2 = dataOut2; cf = cpsrOut; sd = srcDstOut; wv = w;
    rom_log.delete();
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (readyOut !== 1'b1 || romTrigger !== 1'b0 || dataOut1 !== d1 ||
          dataOut2 !== d2 || cpsrOut !== cf || srcDstOut !== sd || w !== wv) ok = 1'b0;
    end
    if (!ok || rom_log.size() != 0) begin
      failures++;
      $display("FAIL hold_stable got=%b/%0d exp=1/0", ok, rom_log.size());
    end
    checks++;
    reset = 1'b0;
    #1;
    all_out = {romAddr, romTrigger, pcOut, pcWrite, rbAddr, rbTrigger, dataOut1,
               dataOut2, cpsrOut, srcDstOut, w, readyOut};
    if (all_out !== '0) begin
      failures++;
      $display("FAIL async_reset got=%h exp=0", all_out);
    end
    checks++;
    repeat (3) @(negedge clk);
    if (romTrigger !== 1'b0 || readyOut !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got=%b/%b exp=0/0", romTrigger, readyOut);
    end
    checks++;
  endtask

  initial begin
    reset = 1'b0;
    triggerIn = 1'b0;
    romReady = 1'b0;
    romData = '0;
    rbReady = 1'b0;
    rbData = '0;
    pcIn = '0;
    cpsrIn = '0;
    rom_word = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    test_reset();
    test_mov();
    test_adds();
    test_cmp_rot();
    test_cond_fail();
    test_back_to_back();
    test_hold_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
